// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 single-wire sensor reader.
// The tick helper converts the clock frequency into cycles per microsecond.
package dht11_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_RELEASE,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_CHECKSUM = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_t;

  localparam int FRAME_W = 40;

  function automatic int us_per_tick(input int clk_hz);
    int t;
    t = clk_hz / 1_000_000;
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for one asynchronous bit; flops reset to RST_VAL.
// Output lags the input by STAGES cycles.
module sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_q <= {STAGES{RST_VAL}};
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/dht11_reader.sv
// DHT11 reader: issues the host start pulse, times the sensor's reply on a
// microsecond base, decodes 40 bits and validates the checksum.
module dht11_reader
  import dht11_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int SYNC_STAGES   = 2,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       data_in,
  output logic       data_oe,
  output logic       busy,
  output logic       done,
  output err_t       err,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec
);

  localparam int TICK    = us_per_tick(CLK_HZ);
  localparam int PRE_W   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int CNT_MAX = (START_LOW_US > TIMEOUT_US)
                         ? ((START_LOW_US > BIT_THRESH_US) ? START_LOW_US : BIT_THRESH_US)
                         : ((TIMEOUT_US > BIT_THRESH_US) ? TIMEOUT_US : BIT_THRESH_US);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state_q;
  logic               data_oe_q, done_q;
  err_t               err_q;
  logic [7:0]         hum_int_q, hum_dec_q, temp_int_q, temp_dec_q;
  logic [PRE_W-1:0]   pre_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [5:0]         bit_cnt_q;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [7:0]         sum_d;
  logic               line_s, line_q;
  logic               rise, fall, tick, tmo, bit_d;

  sync_chain #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (data_in),
    .q_o (line_s)
  );

  assign rise    = line_s & ~line_q;
  assign fall    = ~line_s & line_q;
  assign tick    = (pre_q == PRE_W'(TICK - 1));
  assign tmo     = tick && (cnt_q == CNT_W'(TIMEOUT_US - 1));
  assign bit_d   = (cnt_q > CNT_W'(BIT_THRESH_US));
  assign shift_d = {shift_q[FRAME_W-2:0], bit_d};
  assign sum_d   = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      data_oe_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
      hum_int_q  <= '0;
      hum_dec_q  <= '0;
      temp_int_q <= '0;
      temp_dec_q <= '0;
      pre_q      <= '0;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      line_q     <= 1'b1;
    end else begin
      line_q <= line_s;
      done_q <= 1'b0;
      if (tick) begin
        pre_q <= '0;
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        pre_q <= pre_q + PRE_W'(1);
      end
      // Later assignments below override the timebase so every transition clears it.
      case (state_q)
        S_IDLE: begin
          pre_q <= '0;
          cnt_q <= '0;
          if (start) begin
            state_q   <= S_START_LOW;
            data_oe_q <= 1'b1;
            bit_cnt_q <= '0;
            shift_q   <= '0;
          end
        end
        S_START_LOW: begin
          if (tick && cnt_q == CNT_W'(START_LOW_US - 1)) begin
            state_q   <= S_RELEASE;
            data_oe_q <= 1'b0;
            pre_q     <= '0;
            cnt_q     <= '0;
          end
        end
        S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
          if ((state_q == S_RELEASE && fall) || (state_q == S_RESP_LOW && rise) ||
              (state_q == S_RESP_HIGH && fall) || (state_q == S_BIT_LOW && rise)) begin
            state_q <= state_t'(state_q + 3'd1);
            pre_q   <= '0;
            cnt_q   <= '0;
          end else if (state_q == S_BIT_HIGH && fall) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 6'd1;
            state_q   <= (bit_cnt_q == 6'(FRAME_W - 1)) ? S_CHECK : S_BIT_LOW;
            pre_q     <= '0;
            cnt_q     <= '0;
          end else if (tmo) begin
            state_q   <= S_IDLE;
            done_q    <= 1'b1;
            err_q     <= ERR_TIMEOUT;
            bit_cnt_q <= '0;
            pre_q     <= '0;
            cnt_q     <= '0;
          end
        end
        S_CHECK: begin
          state_q   <= S_IDLE;
          done_q    <= 1'b1;
          bit_cnt_q <= '0;
          pre_q     <= '0;
          cnt_q     <= '0;
          if (sum_d == shift_q[7:0]) begin
            err_q      <= ERR_NONE;
            hum_int_q  <= shift_q[39:32];
            hum_dec_q  <= shift_q[31:24];
            temp_int_q <= shift_q[23:16];
            temp_dec_q <= shift_q[15:8];
          end else begin
            err_q <= ERR_CHECKSUM;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_oe  = data_oe_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign hum_int  = hum_int_q;
  assign hum_dec  = hum_dec_q;
  assign temp_int = temp_int_q;
  assign temp_dec = temp_dec_q;

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader: a behavioural sensor drives the line while a
// scoreboard monitor checks every done pulse against queued expectations.
module tb_dht11_reader;

  localparam int TIMEOUT_US = 200;

  typedef struct packed {
    logic [1:0] err;
    logic [7:0] hi;
    logic [7:0] hd;
    logic [7:0] ti;
    logic [7:0] td;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, sensor_low;
  logic data_in, data_oe, busy, done;
  dht11_pkg::err_t err_w;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Open-drain line with pull-up: low if either side drives it.
  assign data_in = ~(data_oe | sensor_low);

  always #5 clk = ~clk;

  dht11_reader #(
    .CLK_HZ(1_000_000), .SYNC_STAGES(2), .START_LOW_US(100),
    .BIT_THRESH_US(50), .TIMEOUT_US(TIMEOUT_US)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .data_oe(data_oe), .busy(busy), .done(done), .err(err_w),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec)
  );

  function automatic exp_t mk(input logic [1:0] e, input logic [7:0] hi, input logic [7:0] hd,
                              input logic [7:0] ti, input logic [7:0] td);
    exp_t r;
    r.err = e; r.hi = hi; r.hd = hd; r.ti = ti; r.td = td;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        expire("unexpected_done");
      end else begin
        mon_e = sb.pop_front();
        chk("err",      32'(err_w),    32'(mon_e.err));
        chk("hum_int",  32'(hum_int),  32'(mon_e.hi));
        chk("hum_dec",  32'(hum_dec),  32'(mon_e.hd));
        chk("temp_int", 32'(temp_int), 32'(mon_e.ti));
        chk("temp_dec", 32'(temp_dec), 32'(mon_e.td));
      end
    end
  end

  task automatic hold(input logic low, input int n);
    sensor_low = low;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    int i;
    ok = 1'b0;
    for (i = 0; i < 300 && !data_oe; i++) @(negedge clk);
    if (!data_oe) begin expire("start_low_seen"); return; end
    for (i = 0; i < 300 && data_oe; i++) @(negedge clk);
    if (data_oe) begin expire("line_released"); return; end
    ok = 1'b1;
  endtask

  // Sensor reply: 80 low / 80 high, then per bit 50 low + 26 (0) or 70 (1) high.
  // With nbits < 40 the line is left held low to emulate a stuck sensor.
  task automatic sensor(input logic [39:0] f, input int nbits);
    bit ok;
    wait_release(ok);
    if (!ok) return;
    hold(1'b0, 20);
    hold(1'b1, 80);
    hold(1'b0, 80);
    for (int b = 0; b < nbits; b++) begin
      hold(1'b1, 50);
      hold(1'b0, f[39-b] ? 70 : 26);
    end
    if (nbits == 40) begin
      hold(1'b1, 50);
      hold(1'b0, 1);
    end else begin
      sensor_low = 1'b1;
    end
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 8000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) expire(name);
  endtask

  localparam logic [39:0] FRAME_A = 40'h37_00_19_00_50;
  localparam logic [39:0] FRAME_B = 40'h37_00_19_00_51;
  localparam logic [39:0] FRAME_C = 40'h41_05_1E_03_67;

  initial begin
    int  n;
    bit  ok;
    rst = 1'b1; start = 1'b0; sensor_low = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(busy),     0);
    chk("rst_data_oe", 32'(data_oe),  0);
    chk("rst_done",    32'(done),     0);
    chk("rst_err",     32'(err_w),    0);
    chk("rst_hum_int", 32'(hum_int),  0);
    chk("rst_temp",    32'(temp_int), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame: 55 %RH, 25 C.
    sb.push_back(mk(2'd0, 8'd55, 8'd0, 8'd25, 8'd0));
    pulse_start();
    sensor(FRAME_A, 40);
    wait_drain("frame_a_done");

    // Bad checksum keeps the previous reading.
    sb.push_back(mk(2'd1, 8'd55, 8'd0, 8'd25, 8'd0));
    pulse_start();
    sensor(FRAME_B, 40);
    wait_drain("frame_b_done");

    // No response after release: timeout roughly TIMEOUT_US cycles later.
    sb.push_back(mk(2'd2, 8'd55, 8'd0, 8'd25, 8'd0));
    pulse_start();
    wait_release(ok);
    n = 0;
    while (n < 400 && !done) begin @(negedge clk); n++; end
    chk("timeout_latency_in_range", 32'(n >= TIMEOUT_US && n <= TIMEOUT_US + 6), 1);
    wait_drain("no_resp_done");

    // Line stuck low in bit 12.
    sb.push_back(mk(2'd2, 8'd55, 8'd0, 8'd25, 8'd0));
    pulse_start();
    sensor(FRAME_C, 12);
    wait_drain("stuck_low_done");
    sensor_low = 1'b0;
    repeat (10) @(negedge clk);

    // Recovery with a different good frame: 65.5 %RH, 30.3 C.
    sb.push_back(mk(2'd0, 8'd65, 8'd5, 8'd30, 8'd3));
    pulse_start();
    sensor(FRAME_C, 40);
    wait_drain("frame_c_done");

    // Reset during bit 20.
    pulse_start();
    sensor(FRAME_A, 20);
    chk("busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",     32'(busy),     0);
    chk("mid_rst_data_oe",  32'(data_oe),  0);
    chk("mid_rst_hum_int",  32'(hum_int),  0);
    chk("mid_rst_hum_dec",  32'(hum_dec),  0);
    chk("mid_rst_temp_int", 32'(temp_int), 0);
    chk("mid_rst_temp_dec", 32'(temp_dec), 0);
    rst = 1'b0;
    sensor_low = 1'b0;
    repeat (10) @(negedge clk);
    sb.push_back(mk(2'd0, 8'd55, 8'd0, 8'd25, 8'd0));
    pulse_start();
    sensor(FRAME_A, 40);
    wait_drain("post_rst_done");

    // Starts while busy are ignored; a start in the done cycle is taken.
    sb.push_back(mk(2'd0, 8'd65, 8'd5, 8'd30, 8'd3));
    pulse_start();
    fork
      sensor(FRAME_C, 40);
      begin
        repeat (20) @(negedge clk);
        start = 1'b1; @(negedge clk) start = 1'b0;
        repeat (300) @(negedge clk);
        start = 1'b1; @(negedge clk) start = 1'b0;
      end
      begin
        n = 0;
        while (n < 8000 && !done) begin @(negedge clk); n++; end
        if (!done) begin
          expire("busy_frame_done");
        end else begin
          sb.push_back(mk(2'd2, 8'd65, 8'd5, 8'd30, 8'd3));
          start = 1'b1;
          @(negedge clk) start = 1'b0;
          chk("start_in_done_cycle_data_oe", 32'(data_oe), 1);
        end
      end
    join
    wait_drain("done_cycle_start_done");

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
